ysyx_ifu_bpf: RTL and testbench
===============================

# ysyx_ifu_bpf

Parametrised successor fetch unit for the frontend, between the L1I and decode. It replaces the single-entry last-target guess with a direct-mapped BTB of `BTB_SIZE` entries, each holding a 2-bit bimodal counter. Fetched instructions are buffered in a `FQ_DEPTH`-entry fetch queue tagged with their predicted next PC. Backend redirects flush the queue and squash an in-flight fetch, and commit-time branch outcomes train the BTB.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `BTB_SIZE`, 16, BTB entries; power of 2, at least 2. `IDX=log2(BTB_SIZE)`.
- `FQ_DEPTH`, 4, fetch queue entries; power of 2, at least 2.
- `PC_INIT`, 32'h8000_0000, reset fetch PC.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `out_fetch_pc`  out  XLEN  L1I request address.
- `out_fetch_valid`  out  1  L1I request valid.
- `l1i_ready`  in  1  L1I accepts the request this cycle.
- `l1i_rvalid`  in  1  L1I response valid (one per accepted request).
- `l1i_rdata`  in  32  instruction word.
- `out_inst`  out  32  queue head instruction.
- `out_pc`  out  XLEN  queue head PC.
- `out_pnpc`  out  XLEN  queue head predicted next PC.
- `out_pred_taken`  out  1  queue head was predicted taken.
- `out_valid`  out  1  queue not empty.
- `next_ready`  in  1  decode consumes the head.
- `redirect`  in  1  backend redirect / flush.
- `redirect_pc`  in  XLEN  new fetch PC.
- `cmt_valid`  in  1  a control-transfer instruction commits.
- `cmt_pc`  in  XLEN  its PC.
- `cmt_target`  in  XLEN  its resolved target.
- `cmt_taken`  in  1  the branch was taken (1 for jal/jalr).

## Operation
- FSM states: IDLE, WAIT, DROP.
  - IDLE: request when `cnt < FQ_DEPTH`. `cnt` = queue occupancy + in-flight request.
  - IDLE→WAIT when `out_fetch_valid & l1i_ready`.
  - WAIT→IDLE on `l1i_rvalid`.
  - WAIT→DROP on `redirect` without same-cycle `l1i_rvalid`.
  - DROP→IDLE on `l1i_rvalid`; that response is discarded.
- One outstanding request at most.
- BTB lookup happens at request acceptance, using the `fetch_pc` index `pc[IDX+1:2]` and the tag `pc[XLEN-1:IDX+2]`.
  - Hit = entry valid & tag match.
  - Predict taken = hit & `ctr[1]`.
  - `pnpc` = taken ? entry target : `pc+4`.
  - `pnpc` and the taken bit are registered with the request.
  - `fetch_pc <= pnpc` on acceptance.
- Response in WAIT pushes `{pc, inst, pnpc, taken}`. No overflow is possible, because the slot is reserved at issue.
- Pop: `out_valid & next_ready`. Push and pop in the same cycle leave the occupancy unchanged.
- Redirect has priority over every other event in its cycle:
  - The queue is emptied and `fetch_pc <= redirect_pc`.
  - `out_fetch_valid` is forced to 0 in that cycle.
  - A same-cycle `l1i_rvalid` is dropped; the FSM goes to IDLE.
  - The same-cycle pop is ignored.
- BTB training on `cmt_valid`:
  - Hit & taken: `ctr` increments, saturating at 3; `target <= cmt_target`.
  - Hit & not taken: `ctr` decrements, saturating at 0.
  - Miss & taken: allocate (overwrite) with `valid=1`, the tag, the target, and `ctr=2`.
  - Miss & not taken: no change.
- Training is independent of redirect: the same cycle does both.
- A same-cycle lookup and update on the same index sees the old entry.
- PC arithmetic is modulo 2^XLEN; `pc+4` wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values:
  - `out_fetch_valid=0`, `out_valid=0`.
  - `out_inst`, `out_pc`, `out_pnpc`, `out_pred_taken` = 0.
  - `fetch_pc=PC_INIT`, FSM=IDLE.
  - All BTB valid bits cleared; counters = 1.
- Reset mid-fetch: a later `l1i_rvalid` for the abandoned request arrives in IDLE and is ignored.
- The first request is issued in the cycle after reset deasserts.
- Latency: request accepted at cycle N, response at cycle N+k (k≥1). The entry is visible on `out_*` at N+k+1.
  - With `l1i_ready=1` and k=1, throughput is 1 instruction per 2 cycles.
- `out_fetch_pc` is stable while `out_fetch_valid` is held without `l1i_ready`, except on a redirect cycle.
- Prediction uses BTB state as of the acceptance edge. A training write lands at the clock edge and is visible to the next lookup.
- Full boundary: `cnt==FQ_DEPTH` keeps `out_fetch_valid=0`. A same-cycle pop does not enable an issue in that cycle; the issue happens in the next cycle.

## Test plan
- Sequential fetch, BTB empty, from PC 0x8000_0000, `l1i_ready=1`, k=1, `next_ready=1`:
  - `out_pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - `pnpc` = pc+4; `pred_taken=0`.
- Train with `cmt_pc=0x8000_0008`, target 0x8000_0100, taken; then redirect to 0x8000_0000:
  - The entry at 0x8000_0008 is emitted with `pnpc=0x8000_0100` and `pred_taken=1`.
  - The next `out_pc` is 0x8000_0100.
- Counter saturation:
  - Three taken commits then one not-taken: `ctr` goes 2→3→3→2, still predicting taken.
  - Two more not-taken (2→1→0): predicts not taken.
- `next_ready=0`, `FQ_DEPTH=4`:
  - After 4 responses, `out_fetch_valid` stays 0.
  - A single pop re-enables one request in the following cycle.
- Redirect while in WAIT:
  - A redirect to 0x8000_0200 arrives; the response lands 2 cycles later.
  - The stale response is dropped, `out_valid` stays 0 until the 0x8000_0200 instruction arrives, and the queue is empty after the redirect.
- Simultaneous redirect and `cmt_valid`:
  - The BTB is updated and the queue is flushed in the same cycle.
  - Reset asserted mid-WAIT: all outputs return to their reset values and the next fetch is from `PC_INIT`.

Source files
------------

// File: rtl/ysyx_ifu_bpf.sv
// ysyx_ifu_bpf: frontend fetch unit with a direct-mapped bimodal BTB and a
// fetch queue. Requests go to the L1I one at a time. Each buffered
// instruction carries the next PC that was predicted for it. Backend
// redirects flush the queue, and committed branch outcomes train the BTB.
module ysyx_ifu_bpf #(
  parameter int              XLEN     = 32,
  parameter int              BTB_SIZE = 16,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] PC_INIT  = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] out_fetch_pc,
  output logic            out_fetch_valid,
  input  logic            l1i_ready,
  input  logic            l1i_rvalid,
  input  logic [31:0]     l1i_rdata,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pnpc,
  output logic            out_pred_taken,
  output logic            out_valid,
  input  logic            next_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            cmt_valid,
  input  logic [XLEN-1:0] cmt_pc,
  input  logic [XLEN-1:0] cmt_target,
  input  logic            cmt_taken
);
  localparam int IDX  = $clog2(BTB_SIZE);
  localparam int TAGW = XLEN - IDX - 2;
  localparam int QW   = $clog2(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] fetch_pc;

  logic            btb_vld [BTB_SIZE];
  logic [1:0]      btb_ctr [BTB_SIZE];
  logic [TAGW-1:0] btb_tag [BTB_SIZE];
  logic [XLEN-1:0] btb_tgt [BTB_SIZE];

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [31:0]     q_inst  [FQ_DEPTH];
  logic [XLEN-1:0] q_pnpc  [FQ_DEPTH];
  logic            q_taken [FQ_DEPTH];
  logic [QW-1:0]   rd_ptr, wr_ptr;
  logic [QW:0]     occ, cnt;

  logic [XLEN-1:0] req_pc_p1, req_pnpc_p1;
  logic            req_taken_p1;

  logic [IDX-1:0]  lk_idx, tr_idx;
  logic [TAGW-1:0] lk_tag, tr_tag;
  logic            lk_hit, lk_taken, tr_hit;
  logic [XLEN-1:0] lk_pnpc;
  logic            accept, push, pop;

  // BTB lookup on the current fetch PC and the training-port hit check
  assign lk_idx   = IDX'(fetch_pc >> 2);
  assign lk_tag   = TAGW'(fetch_pc >> (IDX + 2));
  assign lk_hit   = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && btb_ctr[lk_idx][1];
  assign lk_pnpc  = lk_taken ? btb_tgt[lk_idx] : fetch_pc + XLEN'(4);

  assign tr_idx = IDX'(cmt_pc >> 2);
  assign tr_tag = TAGW'(cmt_pc >> (IDX + 2));
  assign tr_hit = btb_vld[tr_idx] && (btb_tag[tr_idx] == tr_tag);

  // Occupancy counts the slot reserved by an in-flight request, so a
  // response can never find the queue full.
  assign cnt             = occ + {{QW{1'b0}}, (state == WAIT)};
  assign out_fetch_valid = !reset && !redirect && (state == IDLE) &&
                           (cnt < (QW + 1)'(FQ_DEPTH));
  assign out_fetch_pc    = fetch_pc;
  assign accept          = out_fetch_valid && l1i_ready;
  assign push            = (state == WAIT) && l1i_rvalid && !redirect;
  assign out_valid       = (occ != '0);
  assign pop             = out_valid && next_ready && !redirect;

  assign out_inst       = out_valid ? q_inst[rd_ptr]  : '0;
  assign out_pc         = out_valid ? q_pc[rd_ptr]    : '0;
  assign out_pnpc       = out_valid ? q_pnpc[rd_ptr]  : '0;
  assign out_pred_taken = out_valid && q_taken[rd_ptr];

  // Fetch FSM next-state: a redirect while waiting turns the pending
  // response into one to discard.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = WAIT;
      WAIT: begin
        if (l1i_rvalid)    state_nxt = IDLE;
        else if (redirect) state_nxt = DROP;
      end
      DROP: if (l1i_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register and fetch PC (redirect beats the predicted PC)
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= PC_INIT;
    end else begin
      state <= state_nxt;
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= lk_pnpc;
    end
  end

  // Request stage: the prediction travels with the accepted request
  always_ff @(posedge clock) begin
    if (accept) begin
      req_pc_p1    <= fetch_pc;
      req_pnpc_p1  <= lk_pnpc;
      req_taken_p1 <= lk_taken;
    end
  end

  // Queue control: pointers and occupancy, cleared by reset or redirect
  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (QW + 1)'(1);
        2'b01:   occ <= occ - (QW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Response stage: write the returned instruction with its prediction
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= req_pc_p1;
      q_inst[wr_ptr]  <= l1i_rdata;
      q_pnpc[wr_ptr]  <= req_pnpc_p1;
      q_taken[wr_ptr] <= req_taken_p1;
    end
  end

  // BTB valid bits and saturating counters, trained at commit
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BTB_SIZE; i++) begin
        btb_vld[i] <= 1'b0;
        btb_ctr[i] <= 2'd1;
      end
    end else if (cmt_valid) begin
      if (tr_hit) begin
        if (cmt_taken && btb_ctr[tr_idx] != 2'd3)
          btb_ctr[tr_idx] <= btb_ctr[tr_idx] + 2'd1;
        else if (!cmt_taken && btb_ctr[tr_idx] != 2'd0)
          btb_ctr[tr_idx] <= btb_ctr[tr_idx] - 2'd1;
      end else if (cmt_taken) begin
        btb_vld[tr_idx] <= 1'b1;
        btb_ctr[tr_idx] <= 2'd2;
      end
    end
  end

  // BTB tag/target: any taken commit either refreshes a hit or allocates
  always_ff @(posedge clock) begin
    if (cmt_valid && cmt_taken) begin
      btb_tag[tr_idx] <= tr_tag;
      btb_tgt[tr_idx] <= cmt_target;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_bpf.sv
// Directed bench for ysyx_ifu_bpf. It includes a one-request L1I responder
// with programmable latency and logs every instruction popped by decode.
module tb_ysyx_ifu_bpf;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] out_fetch_pc;
  logic        out_fetch_valid;
  logic        l1i_ready;
  logic        l1i_rvalid;
  logic [31:0] l1i_rdata;
  logic [31:0] out_inst, out_pc, out_pnpc;
  logic        out_pred_taken, out_valid;
  logic        next_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        cmt_valid;
  logic [31:0] cmt_pc, cmt_target;
  logic        cmt_taken;

  ysyx_ifu_bpf dut (
    .clock(clock), .reset(reset),
    .out_fetch_pc(out_fetch_pc), .out_fetch_valid(out_fetch_valid),
    .l1i_ready(l1i_ready), .l1i_rvalid(l1i_rvalid), .l1i_rdata(l1i_rdata),
    .out_inst(out_inst), .out_pc(out_pc), .out_pnpc(out_pnpc),
    .out_pred_taken(out_pred_taken), .out_valid(out_valid),
    .next_ready(next_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_target(cmt_target),
    .cmt_taken(cmt_taken)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // L1I responder state
  int          lat = 1;
  int          cd  = 0;
  bit          pend = 1'b0;
  logic [31:0] paddr;
  bit          acc, rv;
  logic [31:0] acc_pc;

  logic [31:0] pop_pc[$], pop_pnpc[$], pop_inst[$], pop_tk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample, take the edge, then drive the responder.
  task automatic step();
    #1;
    acc    = out_fetch_valid && l1i_ready;
    acc_pc = out_fetch_pc;
    rv     = l1i_rvalid;
    if (out_valid && next_ready && !redirect && !reset) begin
      pop_pc.push_back(out_pc);
      pop_pnpc.push_back(out_pnpc);
      pop_inst.push_back(out_inst);
      pop_tk.push_back({31'd0, out_pred_taken});
    end
    @(posedge clock);
    #1;
    if (rv) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      cd    = lat;
      paddr = acc_pc;
    end
    if (pend) cd--;
    l1i_rvalid = pend && (cd == 0);
    l1i_rdata  = (pend && cd == 0) ? {paddr[15:0], 16'h0013} : 32'h0;
  endtask

  task automatic clear_log();
    pop_pc.delete(); pop_pnpc.delete(); pop_inst.delete(); pop_tk.delete();
  endtask

  task automatic run_pops(input int n, input string tag);
    for (int i = 0; i < 40 && pop_pc.size() < n; i++) step();
    chk(tag, (pop_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    step();
    redirect = 1'b0;
    clear_log();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    cmt_valid = 1'b1; cmt_pc = pc; cmt_target = tgt; cmt_taken = tk;
    step();
    cmt_valid = 1'b0;
  endtask

  task automatic wait_first_wait_cycle(input string tag);
    for (int i = 0; i < 20 && !(pend && cd == 2); i++) step();
    chk(tag, (pend && cd == 2) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; l1i_ready = 1'b1; l1i_rvalid = 1'b0; l1i_rdata = '0;
    next_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    cmt_valid = 1'b0; cmt_pc = '0; cmt_target = '0; cmt_taken = 1'b0;
    @(posedge clock); #1;
    step(); step();

    // Reset values
    chk("rst_fetch_valid", {31'd0, out_fetch_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pnpc", out_pnpc, 32'h0);
    chk("rst_fetch_pc", out_fetch_pc, 32'h8000_0000);

    // Sequential fetch with an empty BTB
    reset = 1'b0;
    #1;
    chk("first_issue", {31'd0, out_fetch_valid}, 32'd1);
    run_pops(3, "seq_timeout");
    chk("seq_pc0", pop_pc[0], 32'h8000_0000);
    chk("seq_pc1", pop_pc[1], 32'h8000_0004);
    chk("seq_pc2", pop_pc[2], 32'h8000_0008);
    chk("seq_pnpc1", pop_pnpc[1], 32'h8000_0008);
    chk("seq_tk2", pop_tk[2], 32'd0);
    chk("seq_inst0", pop_inst[0], 32'h0000_0013);
    chk("seq_inst1", pop_inst[1], 32'h0004_0013);

    // Train a taken branch at 0x8000_0008, then refetch
    commit(32'h8000_0008, 32'h8000_0100, 1'b1);
    redirect_to(32'h8000_0000);
    run_pops(4, "pred_timeout");
    chk("pred_pc2", pop_pc[2], 32'h8000_0008);
    chk("pred_pnpc2", pop_pnpc[2], 32'h8000_0100);
    chk("pred_tk2", pop_tk[2], 32'd1);
    chk("pred_pc3", pop_pc[3], 32'h8000_0100);
    chk("pred_pnpc3", pop_pnpc[3], 32'h8000_0104);

    // Counter saturation: 2 -> 3 -> 3 -> 2 still taken
    commit(32'h8000_0008, 32'h8000_0100, 1'b1);
    commit(32'h8000_0008, 32'h8000_0100, 1'b1);
    commit(32'h8000_0008, 32'h8000_0100, 1'b0);
    redirect_to(32'h8000_0008);
    run_pops(1, "sat_hi_timeout");
    chk("sat_hi_tk", pop_tk[0], 32'd1);
    chk("sat_hi_pnpc", pop_pnpc[0], 32'h8000_0100);
    // 2 -> 1 -> 0: not taken
    commit(32'h8000_0008, 32'h8000_0100, 1'b0);
    commit(32'h8000_0008, 32'h8000_0100, 1'b0);
    redirect_to(32'h8000_0008);
    run_pops(1, "sat_lo_timeout");
    chk("sat_lo_tk", pop_tk[0], 32'd0);
    chk("sat_lo_pnpc", pop_pnpc[0], 32'h8000_000C);
    // Extra not-taken holds 0; one taken reaches 1, still not taken
    commit(32'h8000_0008, 32'h8000_0100, 1'b0);
    commit(32'h8000_0008, 32'h8000_0100, 1'b1);
    redirect_to(32'h8000_0008);
    run_pops(1, "sat_zero_timeout");
    chk("sat_zero_tk", pop_tk[0], 32'd0);

    // Full queue with decode stalled
    next_ready = 1'b0;
    redirect_to(32'h8000_0400);
    for (int i = 0; i < 12; i++) step();
    chk("full_no_issue", {31'd0, out_fetch_valid}, 32'd0);
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_head", out_pc, 32'h8000_0400);
    next_ready = 1'b1;
    #1;
    chk("pop_no_same_issue", {31'd0, out_fetch_valid}, 32'd0);
    step();
    next_ready = 1'b0;
    #1;
    chk("pop_then_issue", {31'd0, out_fetch_valid}, 32'd1);
    chk("pop_then_pc", out_fetch_pc, 32'h8000_0410);
    step();
    chk("reissue_wait", {31'd0, out_fetch_valid}, 32'd0);
    step(); step();
    chk("refull_no_issue", {31'd0, out_fetch_valid}, 32'd0);
    chk("refull_head", out_pc, 32'h8000_0404);

    // Redirect while waiting; the stale response lands two cycles later
    next_ready = 1'b1;
    lat = 3;
    redirect_to(32'h8000_0300);
    wait_first_wait_cycle("drop_setup_timeout");
    redirect_to(32'h8000_0200);
    chk("drop_empty", {31'd0, out_valid}, 32'd0);
    chk("drop_no_issue", {31'd0, out_fetch_valid}, 32'd0);
    step();
    chk("drop_rsp_cycle_empty", {31'd0, out_valid}, 32'd0);
    step();
    chk("drop_after_empty", {31'd0, out_valid}, 32'd0);
    chk("drop_fetch_pc", out_fetch_pc, 32'h8000_0200);
    chk("drop_reissue", {31'd0, out_fetch_valid}, 32'd1);
    run_pops(1, "drop_timeout");
    chk("drop_first_pc", pop_pc[0], 32'h8000_0200);

    // Simultaneous redirect and training
    lat = 1;
    cmt_valid = 1'b1; cmt_pc = 32'h8000_0500; cmt_target = 32'h8000_0600; cmt_taken = 1'b1;
    redirect_to(32'h8000_0500);
    cmt_valid = 1'b0;
    chk("both_flushed", {31'd0, out_valid}, 32'd0);
    run_pops(2, "both_timeout");
    chk("both_pc0", pop_pc[0], 32'h8000_0500);
    chk("both_pnpc0", pop_pnpc[0], 32'h8000_0600);
    chk("both_tk0", pop_tk[0], 32'd1);
    chk("both_pc1", pop_pc[1], 32'h8000_0600);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    run_pops(2, "wrap_timeout");
    chk("wrap_pnpc", pop_pnpc[0], 32'h0);
    chk("wrap_pc1", pop_pc[1], 32'h0);

    // Reset in the middle of a fetch
    lat = 3;
    wait_first_wait_cycle("rstw_setup_timeout");
    reset = 1'b1;
    l1i_ready = 1'b0;
    step();
    chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstw_fetch_valid", {31'd0, out_fetch_valid}, 32'd0);
    chk("rstw_out_pc", out_pc, 32'h0);
    chk("rstw_out_pnpc", out_pnpc, 32'h0);
    chk("rstw_tk", {31'd0, out_pred_taken}, 32'd0);
    chk("rstw_fetch_pc", out_fetch_pc, 32'h8000_0000);
    reset = 1'b0;
    #1;
    chk("rstw_issue", {31'd0, out_fetch_valid}, 32'd1);
    step(); step();
    chk("rstw_stale_ignored", {31'd0, out_valid}, 32'd0);
    chk("rstw_pc_held", out_fetch_pc, 32'h8000_0000);
    l1i_ready = 1'b1;
    lat = 1;
    clear_log();
    run_pops(1, "rstw_timeout");
    chk("rstw_first_pc", pop_pc[0], 32'h8000_0000);
    chk("rstw_first_inst", pop_inst[0], 32'h0000_0013);
    // BTB was cleared by reset
    redirect_to(32'h8000_0500);
    run_pops(1, "btbclr_timeout");
    chk("btbclr_tk", pop_tk[0], 32'd0);
    chk("btbclr_pnpc", pop_pnpc[0], 32'h8000_0504);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
